// File: rtl/seg_mux_n.sv
// Time-multiplexed 7-segment driver: scans N_DIGITS hex digits with a dark
// gap between slots, optional per-digit blanking and leading-zero suppression.
module seg_mux_n #(
  parameter int N_DIGITS    = 2,
  parameter int DIV_COUNT   = 24000,
  parameter int DEAD_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic                    load,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic                    lzs_en,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     anode,
  output logic                    frame_done
);

  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CMAX = (DIV_COUNT > DEAD_CYCLES) ? DIV_COUNT : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_COUNT - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam state_t RST_STATE = (DEAD_CYCLES == 0) ? DRIVE : BLANK;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow;
  logic [N_DIGITS-1:0]     blank_q;
  logic                    lzs_q;

  // blank_mask/lzs_en are resampled every cycle so they act live, yet keep
  // the outputs free of any combinational path from data inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RST_STATE;
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      blank_q <= '0;
      lzs_q   <= 1'b0;
    end else begin
      blank_q <= blank_mask;
      lzs_q   <= lzs_en;
      if (load) shadow <= digits;
      case (state)
        BLANK: begin
          if (cnt == DEAD_LAST) begin
            cnt   <= '0;
            state <= DRIVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRIVE: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            state <= (DEAD_CYCLES == 0) ? DRIVE : BLANK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= RST_STATE;
        end
      endcase
    end
  end

  logic [3:0] nib;
  logic       hi_zero;
  logic       mask_bit;
  logic       dark;
  logic       lit;

  always_comb begin
    nib      = 4'h0;
    hi_zero  = 1'b1;
    mask_bit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (int'(idx) == i) begin
        nib      = shadow[4*i +: 4];
        mask_bit = blank_q[i];
      end
      if (i >= int'(idx) && shadow[4*i +: 4] != 4'h0) hi_zero = 1'b0;
    end
  end

  assign dark = mask_bit || (lzs_q && hi_zero && (idx != '0));
  // Gating with the reset pin darkens the display in the same timestep the
  // reset is asserted, even when the reset state is DRIVE.
  assign lit  = reset && (state == DRIVE) && !dark;

  always_comb begin
    seg = 7'b1111111;
    if (lit) begin
      case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        default: seg = 7'b0001110;
      endcase
    end
  end

  always_comb begin
    anode = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && int'(idx) == i) anode[i] = 1'b0;
    end
  end

  assign frame_done = reset && (state == DRIVE) && (cnt == DIV_LAST) && (idx == IDX_LAST);

endmodule

// File: doc/seg_mux_n.md
SEG_MUX_N -- requirements
Module: seg_mux_n

Interface
REQ-001 SHALL have parameter N_DIGITS, default 2, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV_COUNT, default 24000, clock cycles each digit is driven per slot (legal >=1).
REQ-003 SHALL have parameter DEAD_CYCLES, default 100, all-off cycles between digit slots (legal >=0).
REQ-004 SHALL have port clk, input, 1, single system clock; all flops on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port digits, input, 4*N_DIGITS, hex nibbles, digit i at [4i+3:4i], digit 0 rightmost.
REQ-007 SHALL have port load, input, 1, captures digits into the shadow register.
REQ-008 SHALL have port blank_mask, input, N_DIGITS, 1 forces that digit dark.
REQ-009 SHALL have port lzs_en, input, 1, enables leading-zero suppression.
REQ-010 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port anode, output, N_DIGITS, active-low digit enables, at most one low.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each full scan.

Function
REQ-013 SHALL hold state (BLANK/DRIVE), slot counter cnt, digit index idx and shadow register in flops; seg, anode and frame_done decode combinationally from flops only (no input-to-output combinational path).
REQ-014 SHALL, when load=1 at a rising edge, copy digits into shadow; the displayed value changes from the next cycle, including mid-slot.
REQ-015 SHALL in BLANK drive anode all 1s and seg 7'b1111111; cnt counts 0..DEAD_CYCLES-1, then go to DRIVE with cnt=0.
REQ-016 SHALL skip BLANK entirely when DEAD_CYCLES=0 (DRIVE slots back to back, idx advances directly).
REQ-017 SHALL in DRIVE pull anode[idx] low and output decode of shadow nibble idx; cnt counts 0..DIV_COUNT-1.
REQ-018 SHALL at the last DRIVE cycle advance idx (wrap N_DIGITS-1 -> 0) and go to BLANK (or DRIVE if DEAD_CYCLES=0).
REQ-019 SHALL assert frame_done during exactly the last DRIVE cycle of idx=N_DIGITS-1; with N_DIGITS=1 every slot end.
REQ-020 SHALL decode hex active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL treat a digit as dark when blank_mask[idx]=1, or lzs_en=1 and digit idx and all higher digits are 0 and idx!=0; dark means anode all 1s and seg 1111111 for that slot, slot timing unchanged.
REQ-022 SHALL evaluate blank_mask and lzs_en live each cycle (not shadowed).
REQ-023 SHALL never have two anode bits low in the same cycle, including at slot boundaries.

Reset
REQ-024 SHALL, while reset=0, force state=BLANK (DRIVE if DEAD_CYCLES=0), cnt=0, idx=0, shadow=0, anode all 1s, seg 1111111, frame_done=0, asynchronously.
REQ-025 SHALL, on reset assertion mid-slot, darken outputs immediately and restart the scan at idx 0 after release.

Verification (N_DIGITS=2, DIV_COUNT=4, DEAD_CYCLES=2 unless noted)
REQ-026 SHALL check reset: reset=0 mid-DRIVE -> anode=11, seg=1111111 same timestep; after release 2 BLANK cycles then anode=10.
REQ-027 SHALL check scan: load digits=8'h3A -> after release: 2 cycles anode=11, 4 cycles anode=10 seg=0001000, 2 cycles 11, 4 cycles anode=01 seg=0110000, frame_done high on that 4th cycle only; period 12.
REQ-028 SHALL check lzs: digits=8'h05, lzs_en=1 -> digit1 slot anode=11 seg=1111111, digit0 slot seg=0010010; digits=8'h00 -> digit0 still shows 1000000.
REQ-029 SHALL check blank_mask=2'b01 -> digit0 slot dark, digit1 shown, timing unchanged.
REQ-030 SHALL check mid-slot load: load 8'h11 -> 8'h22 during digit0 DRIVE cycle 2 -> seg 1111001 then 0100100 from next cycle.
REQ-031 SHALL check DEAD_CYCLES=0, N_DIGITS=1: anode=0 constantly, frame_done pulses every 4 cycles.
